argmax_sched: RTL and testbench
===============================

Name: argmax_sched

Overview:
- Sequencer for the 10-way argmax compare pipeline at the end of the classifier datapath.
- Collects the ten 26-bit class scores, which arrive serially from the accumulator over a valid/ready stream, into a score bank that drives the compare pipeline's final0..final9 inputs.
- Holds the bank stable for the pipeline's full latency, then captures the pipeline's Image_Number output.
- Presents the winning class on a valid/ready result interface, with one frame in evaluation at a time.

Parameters:
- SCORE_W, 26: score width; must match the compare pipeline input width.
- NUM_CLASSES, 10: scores per frame; fixed by the compare pipeline.
- CMP_LATENCY, 4: clock edges from the cycle finalN is stable to the cycle Image_Number is valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- score_valid  in  1  score_data/score_last valid.
- score_ready  out  1  block accepts a score this cycle.
- score_data  in  SCORE_W  class score; the k-th accepted score of a frame is class k.
- score_last  in  1  marks the final score of a frame.
- final0..final9  out  SCORE_W each  score bank, to the compare pipeline inputs.
- cmp_image_number  in  4  Image_Number from the compare pipeline.
- result_valid  out  1  result_number valid.
- result_ready  in  1  consumer accepts the result.
- result_number  out  4  winning class index, 0..9.
- busy  out  1  state is not LOAD.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset (asynchronous, takes effect mid-operation too):
  - state=LOAD, cnt=0, final0..9=0, result_valid=0, result_number=0, frame_err=0, eval timer=0.
  - score_ready=1 once the state is LOAD.
- Handshakes:
  - A score transfers on score_valid & score_ready.
  - A result transfers on result_valid & result_ready.
  - score_ready = (state==LOAD). This is a combinational decode of registered state only; it has no path from score_valid.
- LOAD:
  - Each score transfer writes score_data to final[cnt] and increments cnt (0..9).
  - score_last with cnt<9: frame_err pulses the next cycle, cnt->0, the frame is discarded, no launch. Bank contents are don't-care.
  - Transfer at cnt==9 (with or without score_last) completes the frame. If score_last was 0, frame_err pulses anyway and the frame is still evaluated.
  - On completion, cnt->0, then:
    - if (!result_valid || result_ready) -> EVAL;
    - else -> WAIT.
- WAIT:
  - Bank frozen, score_ready=0.
  - Go to EVAL on the first cycle with (!result_valid || result_ready).
- EVAL:
  - Lasts exactly CMP_LATENCY+1 cycles, counted by the eval timer.
  - final0..9 are held constant for every EVAL cycle. The pipeline's class-8/9 pair bypasses two stages, so the bank must stay stable through the final cycle.
  - On the edge ending the last EVAL cycle: result_number<=cmp_image_number, result_valid<=1, state->LOAD.
- Result register:
  - result_valid clears on the result handshake.
  - Capture never occurs while result_valid=1 unless result_ready=1 in the same cycle. This is guaranteed by the launch rule.
  - Capture and handshake in the same cycle: capture wins and result_valid stays 1.
- Latency: the result_valid rising edge occurs exactly CMP_LATENCY+1 (=5) clocks after the 10th score handshake edge when there is no WAIT.
- Throughput: at most one frame in EVAL. New scores are accepted while a result awaits consumption.
- Back-to-back: score_valid held high gives 10 accept cycles, 5 EVAL cycles, and LOAD again, i.e. 15 cycles per frame.
- Ties: resolved by the compare pipeline; the scheduler does not alter cmp_image_number.
- Widths: cnt 4 bits, eval timer ceil(log2(CMP_LATENCY+1)) bits.
- Unused cnt values 10..15 are unreachable; if reached, reset cnt to 0.

Test Plan:
- Gapless frame, scores 100,200,...,1000, result_ready=1 -> result_number=9; result_valid high exactly 5 clocks after the 10th handshake edge for 1 cycle; busy high for 5 cycles; frame_err=0.
- Index-4 max 0x3FFFFFF, others 1, with random score_valid gaps -> result_number=4. Repeat with the max at index 8 -> 8, which exercises the bypass path and bank hold.
- result_ready=0 after frame A (max at 2); send frame B (max at 7) -> B's 10 scores accepted, then busy=1, score_ready=0 (WAIT). Raise result_ready -> result 2 consumed, EVAL starts the next cycle, result 7 appears 5 clocks later.
- score_last on the 6th score -> frame_err single pulse, no result_valid; following valid frame (max at 0) -> result 0.
- 10 scores with score_last=0 (max at 5) -> frame_err pulse and result 5.
- Assert rst_n low during the 3rd EVAL cycle -> all outputs 0 immediately, score_ready=1 after release, no stale result; next frame (max at 3) -> result 3.

Source files
------------

// File: rtl/argmax_sched.sv
// argmax_sched: loads ten serial class scores into a bank that feeds the
// 10-way compare pipeline, holds the bank while the pipeline evaluates, then
// captures the winning class index and offers it on a valid/ready interface.
module argmax_sched #(
    parameter int unsigned SCORE_W     = 26,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned CMP_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    // score stream from the accumulator
    input  logic               score_valid,
    output logic               score_ready,
    input  logic [SCORE_W-1:0] score_data,
    input  logic               score_last,
    // score bank to the compare pipeline
    output logic [SCORE_W-1:0] final0,
    output logic [SCORE_W-1:0] final1,
    output logic [SCORE_W-1:0] final2,
    output logic [SCORE_W-1:0] final3,
    output logic [SCORE_W-1:0] final4,
    output logic [SCORE_W-1:0] final5,
    output logic [SCORE_W-1:0] final6,
    output logic [SCORE_W-1:0] final7,
    output logic [SCORE_W-1:0] final8,
    output logic [SCORE_W-1:0] final9,
    input  logic [3:0]         cmp_image_number,
    // result interface
    output logic               result_valid,
    input  logic               result_ready,
    output logic [3:0]         result_number,
    // status
    output logic               busy,
    output logic               frame_err
);

    localparam int unsigned TIMER_W = $clog2(CMP_LATENCY + 1);
    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CMP_LATENCY);

    typedef enum logic [1:0] {StLoad, StWait, StEval} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [SCORE_W-1:0]  bank_q [NUM_CLASSES];
    logic                result_valid_q, result_valid_d;
    logic [3:0]          result_number_q, result_number_d;
    logic                frame_err_q, frame_err_d;

    logic score_xfer;
    logic result_xfer;
    logic can_launch;
    logic capture;
    logic bank_we;

    assign score_ready = (state_q == StLoad);
    assign busy        = (state_q != StLoad);
    assign score_xfer  = score_valid & score_ready;
    assign result_xfer = result_valid_q & result_ready;
    // A new evaluation may start only if its capture can never overwrite an
    // unconsumed result.
    assign can_launch  = !result_valid_q || result_ready;
    assign bank_we     = score_xfer && (cnt_q <= LAST_IDX);

    // Next-state, load counter and evaluation timer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        frame_err_d = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (cnt_q > LAST_IDX) begin
                    cnt_d = 4'd0;
                end else if (score_xfer) begin
                    if (cnt_q == LAST_IDX) begin
                        // Tenth score completes the frame even without score_last.
                        cnt_d       = 4'd0;
                        frame_err_d = !score_last;
                        timer_d     = '0;
                        state_d     = can_launch ? StEval : StWait;
                    end else if (score_last) begin
                        // Short frame: discard and start over.
                        cnt_d       = 4'd0;
                        frame_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StWait: begin
                if (can_launch) begin
                    timer_d = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                // Bank stays frozen through the last cycle for the 8/9 bypass.
                if (timer_q == TIMER_LAST) begin
                    capture = 1'b1;
                    timer_d = '0;
                    state_d = StLoad;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StLoad;
                cnt_d   = 4'd0;
                timer_d = '0;
            end
        endcase
    end

    // Result register: capture takes priority over the consuming handshake.
    always_comb begin
        result_valid_d  = result_valid_q;
        result_number_d = result_number_q;
        if (result_xfer) begin
            result_valid_d = 1'b0;
        end
        if (capture) begin
            result_valid_d  = 1'b1;
            result_number_d = cmp_image_number;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StLoad;
            cnt_q           <= 4'd0;
            timer_q         <= '0;
            result_valid_q  <= 1'b0;
            result_number_q <= 4'd0;
            frame_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            timer_q         <= timer_d;
            result_valid_q  <= result_valid_d;
            result_number_q <= result_number_d;
            frame_err_q     <= frame_err_d;
        end
    end

    // Score bank: entry cnt is written on each accepted score in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (bank_we && (cnt_q == 4'(i))) begin
                    bank_q[i] <= score_data;
                end
            end
        end
    end

    assign final0 = bank_q[0];
    assign final1 = bank_q[1];
    assign final2 = bank_q[2];
    assign final3 = bank_q[3];
    assign final4 = bank_q[4];
    assign final5 = bank_q[5];
    assign final6 = bank_q[6];
    assign final7 = bank_q[7];
    assign final8 = bank_q[8];
    assign final9 = bank_q[9];

    assign result_valid  = result_valid_q;
    assign result_number = result_number_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_argmax_sched.sv
// Directed bench for argmax_sched with a behavioural compare-pipeline model.
module tb_argmax_sched;

    localparam int SW = 26;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          score_valid;
    logic          score_ready;
    logic [SW-1:0] score_data;
    logic          score_last;
    logic [SW-1:0] final0, final1, final2, final3, final4;
    logic [SW-1:0] final5, final6, final7, final8, final9;
    logic [3:0]    cmp_image_number;
    logic          result_valid;
    logic          result_ready;
    logic [3:0]    result_number;
    logic          busy;
    logic          frame_err;

    int vectors = 0;
    int miscompares = 0;

    logic [SW-1:0] frame [0:9];
    logic [SW-1:0] bank  [0:9];
    logic [SW-1:0] hist  [0:3][0:9];

    argmax_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .score_valid      (score_valid),
        .score_ready      (score_ready),
        .score_data       (score_data),
        .score_last       (score_last),
        .final0           (final0),
        .final1           (final1),
        .final2           (final2),
        .final3           (final3),
        .final4           (final4),
        .final5           (final5),
        .final6           (final6),
        .final7           (final7),
        .final8           (final8),
        .final9           (final9),
        .cmp_image_number (cmp_image_number),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_number    (result_number),
        .busy             (busy),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    assign bank[0] = final0;
    assign bank[1] = final1;
    assign bank[2] = final2;
    assign bank[3] = final3;
    assign bank[4] = final4;
    assign bank[5] = final5;
    assign bank[6] = final6;
    assign bank[7] = final7;
    assign bank[8] = final8;
    assign bank[9] = final9;

    // Compare pipeline model: classes 0..7 seen 4 edges late, 8/9 only 2.
    always @(posedge clk) begin
        for (int k = 0; k < 10; k++) begin
            hist[3][k] <= hist[2][k];
            hist[2][k] <= hist[1][k];
            hist[1][k] <= hist[0][k];
            hist[0][k] <= bank[k];
        end
    end

    always_comb begin
        logic [SW-1:0] best;
        logic [SW-1:0] v;
        best = '0;
        v = '0;
        cmp_image_number = 4'd0;
        for (int k = 0; k < 10; k++) begin
            v = (k < 8) ? hist[3][k] : hist[1][k];
            if (k == 0 || v > best) begin
                best = v;
                cmp_image_number = 4'(k);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input int max_idx, input logic [SW-1:0] max_val,
                             input logic [SW-1:0] other);
        for (int i = 0; i < 10; i++) frame[i] = (i == max_idx) ? max_val : other;
    endtask

    // Sends frame[0..n-1]; returns at the negedge after the last handshake edge.
    task automatic send_frame(input int n, input int last_idx, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int t;
            if (gaps) begin
                score_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            score_valid = 1'b1;
            score_data  = frame[i];
            score_last  = (i == last_idx);
            t = 0;
            while (!score_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!score_ready) chk("score_ready_timeout", 32'(score_ready), 32'd1);
            @(negedge clk);
        end
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int t;
        t = 0;
        while (!result_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(result_valid), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        score_valid  = 1'b0;
        score_data   = '0;
        score_last   = 1'b0;
        result_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_score_ready", 32'(score_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_result_number", 32'(result_number), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_final0", 32'(final0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Gapless ascending frame: latency and busy window
        for (int i = 0; i < 10; i++) frame[i] = SW'(100 * (i + 1));
        send_frame(10, 9, 1'b0);
        chk("t1_final9", 32'(final9), 32'd1000);
        for (int k = 0; k < 5; k++) begin
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_score_ready", 32'(score_ready), 32'd0);
            chk("t1_rv_early", 32'(result_valid), 32'd0);
            chk("t1_frame_err", 32'(frame_err), 32'd0);
            @(negedge clk);
        end
        chk("t1_rv", 32'(result_valid), 32'd1);
        chk("t1_number", 32'(result_number), 32'd9);
        chk("t1_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_rv_pulse", 32'(result_valid), 32'd0);

        // Max at 4 with gaps, then max at 8 (bypass path)
        set_frame(4, 26'h3FFFFFF, 26'd1);
        send_frame(10, 9, 1'b1);
        chk("t2_final4", 32'(final4), 32'h3FFFFFF);
        wait_result("t2a_wait");
        chk("t2a_number", 32'(result_number), 32'd4);
        set_frame(8, 26'h3FFFFFF, 26'd1);
        send_frame(10, 9, 1'b1);
        repeat (4) @(negedge clk);
        chk("t2b_final8_hold", 32'(final8), 32'h3FFFFFF);
        wait_result("t2b_wait");
        chk("t2b_number", 32'(result_number), 32'd8);
        @(negedge clk);

        // Result back-pressure forces WAIT
        result_ready = 1'b0;
        set_frame(2, 26'd5000, 26'd10);
        send_frame(10, 9, 1'b0);
        wait_result("t3a_wait");
        chk("t3a_number", 32'(result_number), 32'd2);
        set_frame(7, 26'd7000, 26'd20);
        send_frame(10, 9, 1'b0);
        chk("t3_wait_ready", 32'(score_ready), 32'd0);
        chk("t3_wait_busy", 32'(busy), 32'd1);
        chk("t3_wait_rv", 32'(result_valid), 32'd1);
        chk("t3_wait_number", 32'(result_number), 32'd2);
        repeat (2) @(negedge clk);
        chk("t3_still_wait", 32'(result_valid), 32'd1);
        result_ready = 1'b1;
        @(negedge clk);
        chk("t3_consumed", 32'(result_valid), 32'd0);
        chk("t3_eval_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_rv_early", 32'(result_valid), 32'd0);
        end
        @(negedge clk);
        chk("t3b_rv", 32'(result_valid), 32'd1);
        chk("t3b_number", 32'(result_number), 32'd7);
        @(negedge clk);

        // Short frame: score_last on the 6th score
        set_frame(1, 26'd900, 26'd5);
        send_frame(6, 5, 1'b0);
        chk("t4_err_pulse", 32'(frame_err), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_err_single", 32'(frame_err), 32'd0);
        repeat (8) @(negedge clk);
        chk("t4_no_result", 32'(result_valid), 32'd0);
        set_frame(0, 26'd1000, 26'd5);
        send_frame(10, 9, 1'b0);
        chk("t4_ok_err", 32'(frame_err), 32'd0);
        wait_result("t4_wait");
        chk("t4_number", 32'(result_number), 32'd0);
        @(negedge clk);

        // Ten scores without score_last
        set_frame(5, 26'd12345, 26'd3);
        send_frame(10, -1, 1'b0);
        chk("t5_err_pulse", 32'(frame_err), 32'd1);
        chk("t5_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t5_err_single", 32'(frame_err), 32'd0);
        wait_result("t5_wait");
        chk("t5_number", 32'(result_number), 32'd5);
        @(negedge clk);

        // Asynchronous reset during the 3rd EVAL cycle
        set_frame(6, 26'd4242, 26'd7);
        send_frame(10, 9, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rv", 32'(result_valid), 32'd0);
        chk("t6_rst_number", 32'(result_number), 32'd0);
        chk("t6_rst_final6", 32'(final6), 32'd0);
        chk("t6_rst_err", 32'(frame_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_ready", 32'(score_ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("t6_no_stale", 32'(result_valid), 32'd0);
        set_frame(3, 26'd800, 26'd2);
        send_frame(10, 9, 1'b0);
        wait_result("t6_wait");
        chk("t6_number", 32'(result_number), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
